naf_recoder: RTL and testbench
==============================

Name: naf_recoder

Overview:
- Upstream scalar-preprocessing stage for the scalar-multiplication core.
- Takes an n-bit scalar and emits its non-adjacent form (NAF) one signed digit per handshake, least-significant digit first, each digit in {-1, 0, +1}.
- The NAF stream drives the multiplier's double/add/subtract sequencing, which cuts the average number of point additions.
- Iterative design: one digit per cycle under a valid/ready handshake, with full backpressure.

Parameters:
- n, 231, scalar width in bits; matches the scalar multiplier.
- IW, 8, width of the digit index; must satisfy 2^IW > n+1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; latches c when idle
- c  input  n  scalar to recode
- busy  output  1  high from accepted start until done
- dig_valid  output  1  digit outputs valid
- dig_ready  input  1  consumer accepts digit
- dig_nz  output  1  digit is nonzero
- dig_neg  output  1  digit is -1 (meaningful only when dig_nz=1)
- dig_idx  output  IW  position of the current digit (weight 2^dig_idx)
- dig_last  output  1  current digit is the most significant nonzero digit
- done  output  1  one-cycle pulse at end of recoding

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset.
- Reset: state IDLE; busy=0, dig_valid=0, dig_nz=0, dig_neg=0, dig_idx=0, dig_last=0, done=0; internal k_reg cleared.
- Internal register: k_reg is n+1 bits wide, because k+1 can carry out of the top bit.
- State IDLE:
  - start=1 latches c into k_reg (zero-extended), clears dig_idx and sets busy=1.
  - Next state is RUN if c!=0, else DONE.
- State RUN:
  - dig_valid=1.
  - Digit is combinational from k_reg[1:0]:
    - k_reg[0]=0 gives 0.
    - k_reg[1:0]=01 gives +1.
    - k_reg[1:0]=11 gives -1.
  - next_k = (k_reg - d) >> 1, where d is the current digit.
  - dig_last = (next_k == 0).
  - On dig_valid && dig_ready: k_reg <= next_k, dig_idx <= dig_idx+1. If dig_last=1, go to DONE.
  - Without dig_ready, all dig_* outputs and k_reg hold stable; there is no limit on stall length.
- State DONE:
  - done=1 for exactly one cycle, busy drops to 0 in the same cycle, dig_valid=0. Next state is IDLE.
- Latency:
  - First digit is valid 1 cycle after the start cycle.
  - At most n+1 digits are emitted.
  - With dig_ready held high: nonzero scalar, done pulses one cycle after the last digit; scalar 0, done pulses 1 cycle after start.
- Output properties:
  - No two adjacent emitted digits are both nonzero.
  - The final digit emitted is always +1.
- Zero scalar: no digit is emitted; only done pulses.
- start while busy: ignored; c is not sampled.
- start in the same cycle as done: ignored; it is accepted only from IDLE.
- reset mid-operation: abort immediately to IDLE on the next edge, with no done pulse and any in-flight digit dropped.
- dig_idx never wraps: the maximum value is n.

Optional Feature:
- Macro: NAF_WEIGHT_EN.
- Defined:
  - Adds output port weight [IW-1:0], counting nonzero digits accepted in the current run.
  - weight is cleared on accepted start and on reset.
  - It is final and stable from the done pulse until the next accepted start.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- c=7, dig_ready=1 -> digits idx0..3 = -1,0,0,+1; dig_last only on idx3; done one cycle later; weight=2 if NAF_WEIGHT_EN.
- c=1 -> single digit +1 at idx0 with dig_last=1; then done. c=0 -> no dig_valid, done 1 cycle after start, busy high exactly 1 cycle.
- c=2^231-1 -> -1 at idx0, zeros at idx1..230, +1 at idx231 with dig_last; 232 digits total; verifies the carry bit of k_reg.
- c=0x2B (43) with dig_ready toggled pseudo-randomly -> NAF -1,0,-1,0,-1,0,+1 (sum 43); outputs stable while stalled; no adjacent nonzero digits.
- Assert reset during RUN at idx3 of c=7 -> next cycle dig_valid=0, busy=0, no done; a fresh start with c=5 -> digits +1,0,+1.
- start pulsed at idx2 of a c=7 run with c=9 -> ignored; original digit stream unchanged.

Source files
------------

// File: rtl/naf_recoder.sv
// Recodes an n-bit scalar into non-adjacent form, one signed digit per handshake, LSD first.
// Optional NAF_WEIGHT_EN adds a count of the nonzero digits accepted in the current run.
module naf_recoder #(
   parameter int n  = 231,
   parameter int IW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [n-1:0]  c,
   output logic          busy,
   output logic          dig_valid,
   input  logic          dig_ready,
   output logic          dig_nz,
   output logic          dig_neg,
   output logic [IW-1:0] dig_idx,
   output logic          dig_last,
`ifdef NAF_WEIGHT_EN
   output logic [IW-1:0] weight,
`endif
   output logic          done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t       state;
   logic [n:0]   k_reg;
   logic [n:0]   next_k;
   logic         run;

   localparam logic [n:0] ONE = {{n{1'b0}}, 1'b1};

   assign run = (state == RUN);

   // Subtracting the digit always leaves k even; a -1 digit needs the extra top bit for the carry.
   always_comb begin
      next_k = k_reg >> 1;
      if (k_reg[1:0] == 2'b11) begin
         next_k = (k_reg + ONE) >> 1;
      end
   end

   assign dig_nz   = run & k_reg[0];
   assign dig_neg  = run & k_reg[0] & k_reg[1];
   assign dig_last = run & (next_k == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         k_reg     <= '0;
         dig_idx   <= '0;
         busy      <= 1'b0;
         dig_valid <= 1'b0;
         done      <= 1'b0;
`ifdef NAF_WEIGHT_EN
         weight    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  k_reg   <= {1'b0, c};
                  dig_idx <= '0;
                  busy    <= 1'b1;
`ifdef NAF_WEIGHT_EN
                  weight  <= '0;
`endif
                  if (c != '0) begin
                     state     <= RUN;
                     dig_valid <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (dig_valid && dig_ready) begin
                  k_reg <= next_k;
`ifdef NAF_WEIGHT_EN
                  weight <= weight + {{(IW-1){1'b0}}, k_reg[0]};
`endif
                  // The index stays on the final digit so it never exceeds n.
                  if (next_k == '0) begin
                     state     <= DONE;
                     dig_valid <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     dig_idx <= dig_idx + IW'(1);
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               dig_valid <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_naf_recoder.sv
// Self-checking bench for naf_recoder: an arithmetic NAF model plus a cycle-level handshake model.
// Build with NAF_WEIGHT_EN defined to also check the weight output.
module tb_naf_recoder;

   localparam int n  = 231;
   localparam int IW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [n-1:0]  c;
   logic          busy;
   logic          dig_valid;
   logic          dig_ready;
   logic          dig_nz;
   logic          dig_neg;
   logic [IW-1:0] dig_idx;
   logic          dig_last;
   logic          done;
`ifdef NAF_WEIGHT_EN
   logic [IW-1:0] weight;
`endif

   int checkCount = 0;
   int errorCount = 0;

   logic [n:0]   expPos = '0;
   logic [n:0]   expNeg = '0;
   int           expCount = 0;
   int           expIdx = 0;
   logic         doneDue = 1'b0;
   int           modelWeight = 0;
   logic [n+1:0] accSum = '0;
   logic [n-1:0] scalarReg = '0;
   logic         prevNz = 1'b0;

   naf_recoder #(.n(n), .IW(IW)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .c(c),
      .busy(busy),
      .dig_valid(dig_valid),
      .dig_ready(dig_ready),
      .dig_nz(dig_nz),
      .dig_neg(dig_neg),
      .dig_idx(dig_idx),
      .dig_last(dig_last),
`ifdef NAF_WEIGHT_EN
      .weight(weight),
`endif
      .done(done)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // NAF by plain arithmetic: odd k picks the digit that makes k-d divisible by 4.
   function automatic void nafModel(input logic [n-1:0] cv, output logic [n:0] pos,
                                    output logic [n:0] neg, output int count);
      logic [n+1:0] k;
      k = {2'b00, cv};
      pos = '0;
      neg = '0;
      count = 0;
      for (int i = 0; i <= n && k != 0; i++) begin
         if (k[0]) begin
            if (k % 4 == 1) begin
               pos[i] = 1'b1;
               k = k - 1;
            end else begin
               neg[i] = 1'b1;
               k = k + 1;
            end
         end
         k = k / 2;
         count = i + 1;
      end
   endfunction

   function automatic logic [n-1:0] randScalar();
      logic [n-1:0] v;
      v = '0;
      for (int w = 0; w < 8; w++) v = {v[n-33:0], 32'($urandom())};
      return v;
   endfunction

   // Compares outputs against the model, then advances the model by what the next edge will do.
   task automatic checkCycle();
      logic         expValid;
      logic         expBusy;
      logic         expNz;
      logic [n+1:0] term;
      expValid = (expIdx < expCount);
      expBusy  = expValid || doneDue;
      expNz    = 1'b0;
      checkOutput("busy", 256'(busy), 256'(expBusy));
      checkOutput("dig_valid", 256'(dig_valid), 256'(expValid));
      checkOutput("done", 256'(done), 256'(doneDue));
`ifdef NAF_WEIGHT_EN
      checkOutput("weight", 256'(weight), 256'(modelWeight));
`endif
      if (expValid) begin
         expNz = expPos[expIdx] | expNeg[expIdx];
         checkOutput("dig_nz", 256'(dig_nz), 256'(expNz));
         if (expNz) checkOutput("dig_neg", 256'(dig_neg), 256'(expNeg[expIdx]));
         checkOutput("dig_idx", 256'(dig_idx), 256'(expIdx));
         checkOutput("dig_last", 256'(dig_last), 256'(expIdx == expCount - 1));
      end
      if (reset) begin
         expIdx = 0;
         expCount = 0;
         doneDue = 1'b0;
         modelWeight = 0;
      end else begin
         doneDue = 1'b0;
         if (expValid && dig_ready) begin
            checkOutput("adjacent_nz", 256'(prevNz && dig_nz), 256'(0));
            term = {{(n+1){1'b0}}, 1'b1} << dig_idx;
            if (dig_nz) accSum = dig_neg ? accSum - term : accSum + term;
            prevNz = dig_nz;
            if (expNz) modelWeight++;
            expIdx++;
            if (expIdx == expCount) begin
               doneDue = 1'b1;
               checkOutput("naf_sum", 256'(accSum), 256'({2'b00, scalarReg}));
            end
         end else if (start && !expBusy) begin
            nafModel(c, expPos, expNeg, expCount);
            expIdx = 0;
            modelWeight = 0;
            accSum = '0;
            prevNz = 1'b0;
            scalarReg = c;
            doneDue = (expCount == 0);
         end
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic rdy, input logic st, input logic [n-1:0] cv);
      reset = rst;
      dig_ready = rdy;
      start = st;
      c = cv;
      checkCycle();
      @(negedge clk);
   endtask

   // Drives until the model goes idle, with random backpressure and ignored spurious starts.
   task automatic runTail(input int readyPct);
      int   budget;
      logic rdy;
      logic st;
      budget = 4000;
      while ((expIdx < expCount || doneDue) && budget > 0) begin
         rdy = ($urandom_range(0, 99) < readyPct);
         st  = ($urandom_range(0, 9) == 0);
         applyStimulus(1'b0, rdy, st, randScalar());
         budget--;
      end
      if (expIdx < expCount || doneDue) checkOutput("run_timeout", 256'(1), 256'(0));
   endtask

   task automatic runScalar(input logic [n-1:0] cv, input int readyPct);
      applyStimulus(1'b0, 1'b1, 1'b1, cv);
      runTail(readyPct);
   endtask

   initial begin
      logic [n:0] p;
      logic [n:0] m;
      int         cnt;
      reset = 1'b1;
      start = 1'b0;
      dig_ready = 1'b0;
      c = '0;
      @(negedge clk);
      checkOutput("reset_busy", 256'(busy), 256'(0));
      checkOutput("reset_dig_valid", 256'(dig_valid), 256'(0));
      checkOutput("reset_done", 256'(done), 256'(0));
      checkOutput("reset_dig_idx", 256'(dig_idx), 256'(0));
      checkOutput("reset_dig_nz", 256'(dig_nz), 256'(0));
      checkOutput("reset_dig_neg", 256'(dig_neg), 256'(0));
      checkOutput("reset_dig_last", 256'(dig_last), 256'(0));
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      applyStimulus(1'b1, 1'b0, 1'b0, '0);

      // Hand-derived NAFs pin the model before it judges the DUT.
      nafModel(n'(7), p, m, cnt);
      checkOutput("model7_pos", 256'(p), 256'(8));
      checkOutput("model7_neg", 256'(m), 256'(1));
      checkOutput("model7_count", 256'(cnt), 256'(4));
      nafModel(n'(43), p, m, cnt);
      checkOutput("model43_pos", 256'(p), 256'(64));
      checkOutput("model43_neg", 256'(m), 256'(21));
      checkOutput("model43_count", 256'(cnt), 256'(7));
      nafModel(n'(9), p, m, cnt);
      checkOutput("model9_pos", 256'(p), 256'(9));
      checkOutput("model9_count", 256'(cnt), 256'(4));
      nafModel('1, p, m, cnt);
      checkOutput("modelmax_pos", 256'(p), 256'(1) << 231);
      checkOutput("modelmax_neg", 256'(m), 256'(1));
      checkOutput("modelmax_count", 256'(cnt), 256'(232));
      nafModel('0, p, m, cnt);
      checkOutput("model0_count", 256'(cnt), 256'(0));

      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      runScalar(n'(7), 100);
`ifdef NAF_WEIGHT_EN
      checkOutput("weight_c7", 256'(weight), 256'(2));
`endif
      runScalar(n'(1), 100);
      runScalar('0, 100);
      runScalar('1, 100);
      runScalar(n'(43), 50);

      // Reset while digit 3 of c=7 is presented, then a fresh c=5 run.
      applyStimulus(1'b0, 1'b1, 1'b1, n'(7));
      while (expIdx < 3) applyStimulus(1'b0, 1'b1, 1'b0, '0);
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      runScalar(n'(5), 100);

      // A start with c=9 at digit 2 of a c=7 run must be ignored.
      applyStimulus(1'b0, 1'b1, 1'b1, n'(7));
      while (expIdx < 2) applyStimulus(1'b0, 1'b1, 1'b0, '0);
      applyStimulus(1'b0, 1'b1, 1'b1, n'(9));
      runTail(100);

      for (int r = 0; r < 20; r++) begin
         logic [n-1:0] v;
         v = randScalar();
         if (r % 4 == 0) v = n'($urandom_range(0, 255));
         runScalar(v, $urandom_range(30, 100));
      end
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      applyStimulus(1'b0, 1'b1, 1'b0, '0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
